// File: rtl/bsg_dff_share_arb_pkg.sv
// Shared constants, tag sizing and lock-state encoding for bsg_dff_share_arb.
// The lock-state enum is used only when BSG_DFF_SHARE_ARB_LOCK_EN is defined.
package bsg_dff_share_arb_pkg;

  localparam int els_min_lp = 2;
  localparam int els_max_lp = 16;

  function automatic int tag_width(input int els);
    return (els > 1) ? $clog2(els) : 1;
  endfunction

  typedef enum logic {
    e_idle   = 1'b0,
    e_locked = 1'b1
  } lock_state_e;

endpackage

// File: rtl/bsg_round_robin_pick.sv
// Combinational round-robin pick: lowest requester at or after ptr_i, wrapping to 0.
module bsg_round_robin_pick
  import bsg_dff_share_arb_pkg::*;
#(
  parameter  int els_p     = 4,
  localparam int lg_els_lp = tag_width(els_p)
) (
  input  logic [els_p-1:0]     req_i,
  input  logic [lg_els_lp-1:0] ptr_i,
  output logic [els_p-1:0]     grant_o,
  output logic [lg_els_lp-1:0] idx_o,
  output logic                 v_o
);

  logic [els_p-1:0] upper_mask;
  logic [els_p-1:0] upper_req;
  logic [els_p-1:0] search_req;

  // Requests at or above the pointer win; otherwise wrap to the full vector.
  for (genvar gi = 0; gi < els_p; gi++) begin : g_mask
    assign upper_mask[gi] = (lg_els_lp'(gi) >= ptr_i);
  end

  assign upper_req  = req_i & upper_mask;
  assign search_req = (|upper_req) ? upper_req : req_i;
  assign v_o        = |req_i;

  always_comb begin
    idx_o = '0;
    for (int i = els_p - 1; i >= 0; i--) begin
      if (search_req[i]) idx_o = lg_els_lp'(i);
    end
  end

  for (genvar gi = 0; gi < els_p; gi++) begin : g_grant
    assign grant_o[gi] = v_o & (idx_o == lg_els_lp'(gi));
  end

endmodule

// File: rtl/bsg_dff_share_arb.sv
// Round-robin arbiter sharing one reset-to-zero pipeline register among els_p requesters.
// Define BSG_DFF_SHARE_ARB_LOCK_EN to add last_i and hold arbitration for whole bursts.
module bsg_dff_share_arb
  import bsg_dff_share_arb_pkg::*;
#(
  parameter  int els_p     = 4,
  parameter  int width_p   = 16,
  localparam int lg_els_lp = tag_width(els_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [els_p-1:0]         v_i,
  input  logic [els_p*width_p-1:0] data_i,
`ifdef BSG_DFF_SHARE_ARB_LOCK_EN
  input  logic [els_p-1:0]         last_i,
`endif
  output logic [els_p-1:0]         yumi_o,
  output logic                     v_o,
  output logic [width_p-1:0]       data_o,
  output logic [lg_els_lp-1:0]     tag_o,
  input  logic                     yumi_i
);

  if (els_p < els_min_lp || els_p > els_max_lp) begin : g_bad_els
    $error("bsg_dff_share_arb: els_p out of range");
  end

  logic                 v_reg, v_next;
  logic [width_p-1:0]   data_reg, data_next;
  logic [lg_els_lp-1:0] tag_reg, tag_next;
  logic [lg_els_lp-1:0] ptr_reg, ptr_next;

  logic                 open;
  logic [els_p-1:0]     pick_grant;
  logic [lg_els_lp-1:0] pick_idx;
  logic                 pick_v;

  logic                 grant_v;
  logic [lg_els_lp-1:0] grant_idx;
  logic [els_p-1:0]     grant_oh;
  logic                 advance;

  assign open = ~v_reg | yumi_i;

  bsg_round_robin_pick #(.els_p(els_p)) pick (
    .req_i   (v_i),
    .ptr_i   (ptr_reg),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .v_o     (pick_v)
  );

`ifdef BSG_DFF_SHARE_ARB_LOCK_EN
  lock_state_e      state_reg, state_next;
  logic [els_p-1:0] lock_oh;

  // While locked, tag_reg still names the burst owner since only it can be granted.
  for (genvar gi = 0; gi < els_p; gi++) begin : g_lock_oh
    assign lock_oh[gi] = (tag_reg == lg_els_lp'(gi));
  end

  always_comb begin
    state_next = state_reg;
    grant_v    = 1'b0;
    grant_idx  = pick_idx;
    grant_oh   = pick_grant;
    advance    = 1'b0;
    case (state_reg)
      e_idle: begin
        grant_v = open & pick_v;
        advance = grant_v & last_i[pick_idx];
        if (grant_v & ~last_i[pick_idx]) state_next = e_locked;
      end
      e_locked: begin
        grant_idx = tag_reg;
        grant_oh  = lock_oh;
        grant_v   = open & v_i[tag_reg];
        if (grant_v & last_i[tag_reg]) begin
          state_next = e_idle;
          advance    = 1'b1;
        end
      end
      default: state_next = e_idle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) state_reg <= e_idle;
    else         state_reg <= state_next;
  end
`else
  assign grant_v   = open & pick_v;
  assign grant_idx = pick_idx;
  assign grant_oh  = pick_grant;
  assign advance   = grant_v;
`endif

  assign yumi_o = (grant_v & ~reset_i) ? grant_oh : '0;

  always_comb begin
    v_next    = v_reg;
    data_next = data_reg;
    tag_next  = tag_reg;
    ptr_next  = ptr_reg;
    if (grant_v) begin
      v_next    = 1'b1;
      data_next = data_i[grant_idx*width_p +: width_p];
      tag_next  = grant_idx;
    end else if (open) begin
      v_next = 1'b0;
    end
    if (advance) begin
      ptr_next = (grant_idx == lg_els_lp'(els_p - 1)) ? '0 : grant_idx + lg_els_lp'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      v_reg    <= 1'b0;
      data_reg <= '0;
      tag_reg  <= '0;
      ptr_reg  <= '0;
    end else begin
      v_reg    <= v_next;
      data_reg <= data_next;
      tag_reg  <= tag_next;
      ptr_reg  <= ptr_next;
    end
  end

  assign v_o    = v_reg;
  assign data_o = data_reg;
  assign tag_o  = tag_reg;

endmodule

// File: doc/bsg_dff_share_arb.md
# bsg_dff_share_arb

Round-robin arbiter that shares one reset-to-zero width_p-bit pipeline register among els_p requesters. Each requester offers data with valid/yumi; the winner's word is captured into the shared register and presented downstream with valid/yumi and a source tag. It sits in front of the team's reset flop datapath wherever several producers must time-share a single registered output lane.

## Interface
- els_p, default 4: number of requesters; legal range 2..16.
- width_p, default 16: data width per requester.
- lg_els_lp: derived, $clog2(els_p); not overridable.
- clk_i  input  1  single clock; all state updates on posedge.
- reset_i  input  1  synchronous, active-high reset.
- v_i  input  els_p  per-requester valid.
- data_i  input  els_p*width_p  requester k's word is in bits [k*width_p +: width_p].
- yumi_o  output  els_p  one-hot (or zero) accept; the word on data_i is consumed this cycle.
- v_o  output  1  shared register holds a valid word.
- data_o  output  width_p  shared register contents.
- tag_o  output  lg_els_lp  index of the requester whose word is in data_o.
- yumi_i  input  1  downstream consumes data_o this cycle; legal only when v_o=1.
- last_i  input  els_p  present only with BSG_DFF_SHARE_ARB_LOCK_EN; marks the final beat of a burst.

## Operation
- Reset values: v_o=0, data_o=0, tag_o=0, yumi_o=0, priority pointer=0 (requester 0 highest), lock state idle.
- Register "open" = (v_o==0) | yumi_i. yumi_o is nonzero only when open.
- When open and any v_i set: grant the first set v_i at or after the pointer, wrapping modulo els_p. yumi_o[g]=1, and the next cycle has data_o=data_i[g], tag_o=g, v_o=1.
- When open and no v_i is set: v_o becomes 0. data_o and tag_o hold their last values; they are not cleared.
- When not open (v_o=1, yumi_i=0): hold data_o, tag_o, and v_o. yumi_o=0.
- Pointer update: only on a grant, pointer <= (g+1) mod els_p. With no grant the pointer holds.
- Fairness: with all requesters continuously valid and the register drained every cycle, grants rotate 0,1,..,els_p-1,0,...
- Simultaneous drain and load (yumi_i=1 with a new grant): back-to-back; v_o stays 1 with new data.
- yumi_o is combinational from v_i, v_o, yumi_i, and state. No combinational path exists from data_i to any handshake output.
- Reset mid-operation: any held word is discarded and no yumi_o is asserted during reset. All state returns to reset values the cycle after reset_i.

## Timing
- Data latency: 1 cycle from the yumi_o[g] cycle to data_o valid.
- Throughput: 1 word per cycle when downstream asserts yumi_i every cycle.
- Response latency: a requester waits at most els_p-1 grants (els_p-1 bursts in lock mode) once it is valid.
- A requester may drop v_i only after it has been yumi'd.

## Configuration
- BSG_DFF_SHARE_ARB_LOCK_EN defined:
  - The last_i port exists.
  - After a grant to g with last_i[g]=0, arbitration locks to g. Subsequent grants go only to g, even if others are valid, until a beat with last_i[g]=1 is accepted; the lock then releases.
  - The pointer advances only on the releasing beat.
  - While locked and v_i[g]=0, no grant occurs and the lock holds.
- BSG_DFF_SHARE_ARB_LOCK_EN undefined: the last_i port is absent and every beat re-arbitrates.

## Structure
- Package bsg_dff_share_arb_pkg holds:
  - the els_p legal bounds as constants;
  - the tag type width function;
  - the lock-state enum (e_idle, e_locked), compiled but unused when the macro is off.
- Sub-module bsg_round_robin_pick: combinational. Inputs are the request vector and the pointer; outputs are the one-hot grant and the encoded index.
- The top level contains the shared register, the pointer, and the lock flops.

## Test plan
- Reset, then idle: hold reset_i 2 cycles with v_i=4'b1111. Required: yumi_o=0 and v_o=0, data_o=0, tag_o=0 during and after reset.
- Rotation: v_i=1111, data_i words 0xA000+k, yumi_i=1 always. Required: tag_o sequence 0,1,2,3,0 with matching data_o, one per cycle after a 1-cycle latency.
- Backpressure: hold yumi_i=0 for 3 cycles with v_o=1. Required: yumi_o=0, and data_o/tag_o stable. Raising yumi_i produces a same-cycle regrant.
- Wrap and skip: pointer=3 with v_i=0101. Required: grant 0 and pointer becomes 1; next grant 2 and pointer becomes 3.
- Drain to empty: a single grant, then v_i=0 with yumi_i=1. Required: v_o falls to 0 and data_o holds the last word.
- Lock (macro on): requester 1 sends 3 beats with last_i=0,0,1 while v_i=1111. Required: tags 1,1,1 appear, then tag 2.
